// File: rtl/alu_32_bit.sv
// Registered 32-bit ALU for the MIPS execute stage: AND, OR, ADD, SUB and signed SLT.
// Result, carry-out and zero flag are all captured on the same rising edge.
module alu_32_bit (
  input  logic        clk,
  input  logic        rst_n,
  output logic        carryOut,
  output logic [31:0] outputAlu,
  output logic        Z,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        carryIn,
  input  logic [2:0]  AluOp
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [32:0] add_sum_s;
  logic [32:0] sub_sum_s;
  logic        slt_ovf_s;
  logic [31:0] result_d;
  logic        carry_d;
  logic        zero_d;
  logic [31:0] result_q;
  logic        carry_q;
  logic        zero_q;

  // Next-state result, carry and zero from the operation selected this cycle
  always_comb begin
    add_sum_s = {1'b0, a} + {1'b0, b} + {32'd0, carryIn};
    sub_sum_s = {1'b0, a} + {1'b0, ~b} + 33'd1;
    slt_ovf_s = (a[31] != b[31]) && (sub_sum_s[31] != a[31]);
    result_d  = 32'd0;
    carry_d   = 1'b0;
    case (AluOp)
      OP_AND: result_d = a & b;
      OP_OR:  result_d = a | b;
      OP_ADD: {carry_d, result_d} = add_sum_s;
      OP_SUB: {carry_d, result_d} = sub_sum_s;
      OP_SLT: begin
        result_d = {31'd0, sub_sum_s[31] ^ slt_ovf_s};
        carry_d  = sub_sum_s[32];
      end
      default: begin
        result_d = 32'd0;
        carry_d  = 1'b0;
      end
    endcase
    // Zero tracks the value being registered, never the held one
    zero_d = ~|result_d;
  end

  // Output stage with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= 32'd0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  assign outputAlu = result_q;
  assign carryOut  = carry_q;
  assign Z         = zero_q;

endmodule

// File: tb/tb_alu_32_bit.sv
// Scoreboard bench for alu_32_bit: the driver queues expected results from a
// plain-arithmetic model, and a monitor compares them one edge later.
module tb_alu_32_bit;

  logic        clk;
  logic        rst_n;
  logic        carryOut;
  logic [31:0] outputAlu;
  logic        Z;
  logic [31:0] a;
  logic [31:0] b;
  logic        carryIn;
  logic [2:0]  AluOp;

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        z;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  alu_32_bit dut (
    .clk(clk), .rst_n(rst_n), .carryOut(carryOut), .outputAlu(outputAlu),
    .Z(Z), .a(a), .b(b), .carryIn(carryIn), .AluOp(AluOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] x,
                                 input logic [31:0] y, input logic ci, input string nm);
    exp_t        e;
    logic [63:0] t;
    e.res  = 32'd0;
    e.c    = 1'b0;
    e.name = nm;
    t      = 64'd0;
    case (op)
      3'b000: e.res = x & y;
      3'b001: e.res = x | y;
      3'b010: begin
        t     = 64'(x) + 64'(y) + 64'(ci);
        e.res = t[31:0];
        e.c   = t[32];
      end
      3'b110: begin
        e.res = x - y;
        e.c   = (x >= y);
      end
      3'b111: begin
        e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
        e.c   = (x >= y);
      end
      default: begin
        e.res = 32'd0;
        e.c   = 1'b0;
      end
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  task automatic issue(input logic rst, input logic [2:0] op, input logic [31:0] x,
                       input logic [31:0] y, input logic ci, input string nm);
    exp_t e;
    @(negedge clk);
    rst_n   = rst;
    AluOp   = op;
    a       = x;
    b       = y;
    carryIn = ci;
    if (!rst) begin
      e.res  = 32'd0;
      e.c    = 1'b0;
      e.z    = 1'b1;
      e.name = nm;
    end else begin
      e = model(op, x, y, ci, nm);
    end
    exp_q.push_back(e);
  endtask

  // Monitor: every edge presents a result for the op sampled at that edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (outputAlu !== e.res || carryOut !== e.c || Z !== e.z) begin
          errors++;
          $display("FAIL %s: got res=%h c=%b z=%b, expected res=%h c=%b z=%b",
                   e.name, outputAlu, carryOut, Z, e.res, e.c, e.z);
        end
      end
    end
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    a       = 32'd0;
    b       = 32'd0;
    carryIn = 1'b0;
    AluOp   = 3'b000;

    issue(1'b0, 3'b010, 32'hFFFFFFFF, 32'h00000001, 1'b1, "reset0");
    issue(1'b0, 3'b001, 32'h12345678, 32'h9ABCDEF0, 1'b0, "reset1");
    issue(1'b1, 3'b000, 32'hED5AB56A, 32'h5EFDFBF7, 1'b0, "and");
    issue(1'b1, 3'b001, 32'hAAAAAAAA, 32'h63636363, 1'b0, "or");
    issue(1'b1, 3'b010, 32'h2A2A2A2A, 32'h2A2A2A2A, 1'b0, "add");
    issue(1'b1, 3'b010, 32'hFFFFFFFF, 32'h00000001, 1'b0, "add_wrap");
    issue(1'b1, 3'b010, 32'h00000000, 32'h00000000, 1'b1, "add_cin");
    issue(1'b1, 3'b110, 32'h7A7A7A7A, 32'h2A2A2A2A, 1'b0, "sub");
    issue(1'b1, 3'b110, 32'h12345678, 32'h12345678, 1'b1, "sub_eq_cin");
    issue(1'b1, 3'b110, 32'h00000000, 32'h00000001, 1'b0, "sub_borrow");
    issue(1'b1, 3'b111, 32'hA0000000, 32'hB0000000, 1'b0, "slt_neg");
    issue(1'b1, 3'b111, 32'h7FFFFFFF, 32'h80000000, 1'b0, "slt_ovf");
    issue(1'b1, 3'b111, 32'h80000000, 32'h00000001, 1'b0, "slt_min");
    issue(1'b1, 3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, "pipe_and");
    issue(1'b1, 3'b010, 32'h80000000, 32'h80000000, 1'b1, "pipe_add");
    issue(1'b1, 3'b110, 32'h00000005, 32'h00000009, 1'b0, "pipe_sub");
    issue(1'b1, 3'b111, 32'h00000005, 32'h00000009, 1'b0, "pipe_slt");
    issue(1'b1, 3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "unused101");
    issue(1'b1, 3'b011, 32'h12345678, 32'h0000FFFF, 1'b1, "unused011");
    issue(1'b1, 3'b100, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0, "unused100");
    issue(1'b0, 3'b001, 32'hFFFFFFFF, 32'h00000000, 1'b0, "reset_mid");

    for (int i = 0; i < 400; i++) begin
      op = 3'($urandom_range(0, 7));
      x  = $urandom;
      y  = $urandom;
      case ($urandom_range(0, 3))
        0: y = x;
        1: x = {x[31], 31'($urandom_range(0, 3))};
        default: ;
      endcase
      issue(($urandom_range(0, 31) != 0), op, x, y, 1'($urandom), "random");
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results never observed, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
